// File: rtl/fiat_25519_mul_pipe_vld.sv
// fiat_25519_mul_pipe_vld: pipelined signed/unsigned multiplier with valid chain and optional accumulator.
module fiat_25519_mul_pipe_vld #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 32,
    parameter int din1_WIDTH = 32,
    parameter int dout_WIDTH = 64,
    parameter int SIGNED0    = 0,
    parameter int SIGNED1    = 0,
    parameter int ACC_EN     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_vld,
    input  logic                  acc_clr,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  out_vld
);
    localparam int L  = NUM_STAGE - 1;
    localparam int PW = din0_WIDTH + din1_WIDTH + 2;
    localparam int XW = (PW > dout_WIDTH) ? PW : dout_WIDTH;
    localparam int CW = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;

    // Extending both operands to XW makes the truncated product equal the
    // truncated or sign-extended full-width product in one multiply.
    logic [XW-1:0]         a_x, b_x;
    logic [dout_WIDTH-1:0] prod;
    logic [dout_WIDTH-1:0] d_q [NUM_STAGE];
    logic [dout_WIDTH-1:0] d_d [NUM_STAGE];
    logic [dout_WIDTH-1:0] d_s [NUM_STAGE];
    logic [NUM_STAGE-1:0]  v_q, v_d;
    logic [CW-1:0]         c_q, c_d;
    logic                  clr_s;

    assign a_x  = {{(XW-din0_WIDTH){(SIGNED0 != 0) & din0[din0_WIDTH-1]}}, din0};
    assign b_x  = {{(XW-din1_WIDTH){(SIGNED1 != 0) & din1[din1_WIDTH-1]}}, din1};
    assign prod = dout_WIDTH'(a_x * b_x);

    always_comb begin
        d_s[0] = prod;
        v_d[0] = in_vld;
        c_d[0] = acc_clr;
        for (int i = 1; i < NUM_STAGE; i++) begin
            d_s[i] = d_q[i-1];
            v_d[i] = v_q[i-1];
        end
        for (int i = 1; i < CW; i++) c_d[i] = c_q[i-1];
        clr_s = (NUM_STAGE == 1) ? acc_clr : c_q[CW-1];
        d_d = d_s;
        // In accumulate mode the last stage is the accumulator itself.
        if (ACC_EN != 0)
            d_d[L] = v_d[L] ? (clr_s ? d_s[L] : d_q[L] + d_s[L]) : d_q[L];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q <= '{default: '0};
            v_q <= '0;
            c_q <= '0;
        end else if (ce) begin
            d_q <= d_d;
            v_q <= v_d;
            c_q <= c_d;
        end
    end

    assign dout    = d_q[L];
    assign out_vld = v_q[L];
endmodule
